// File: rtl/mem_stage_pkg.sv
// Shared defines for the MEM stage: opcodes, load/store funct3 codes, NOP word and the MEM/WB entry.
// Pure definitions, no timing or backpressure of its own.
package mem_stage_pkg;

  localparam logic [6:0] INST_TYPE_L = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] INST_NOP = 32'h00000013;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] data;
    logic [31:0] data_men;
    logic [31:0] pc_next;
    logic [4:0]  wbaddr;
  } wb_t;

  function automatic wb_t wb_bubble();
    wb_t b;
    b       = '0;
    b.instr = INST_NOP;
    return b;
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return addr[0];
      default: return |addr;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: selects byte/half/word by address and sign- or zero-extends.
// Combinational, no backpressure.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    result  = rdata;
    case (funct3)
      F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  result = {24'b0, shifted[7:0]};
      F3_LHU:  result = {16'b0, shifted[15:0]};
      F3_LW:   result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory requests, aligns load data, registers the MEM/WB entry.
// Non-memory ops take 1 cycle; loads/stores stall upstream until ack or ACK_TIMEOUT wait cycles.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] data_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] pc_next_i,
  input  logic [4:0]  wbaddr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] data_men_o,
  output logic [31:0] data_o,
  output logic [31:0] pc_next_o,
  output logic [31:0] instr_o,
  output logic [4:0]  wbaddr_o,
  output logic        valid_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] instr_q, data_q, pc_q;
  logic [4:0]  wbaddr_q;
  wb_t         wb_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, is_mem, bad_align, start, timeout;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, load_result;

  assign opcode    = instr_i[6:0];
  assign funct3    = instr_i[14:12];
  assign is_load   = (opcode == INST_TYPE_L);
  assign is_store  = (opcode == INST_TYPE_S);
  assign is_mem    = is_load || is_store;
  assign bad_align = is_mem && misaligned(funct3, data_i[1:0]);
  assign start     = (state == S_IDLE) && valid_i && is_mem && !bad_align;
  assign timeout   = (state == S_WAIT) && !dmem_ack_i && (wait_cnt == 8'(ACK_TIMEOUT - 1));
  // The timeout cycle releases the freeze so the faulted instruction retires instead of reissuing.
  assign stall_o   = start || ((state == S_WAIT) && !dmem_ack_i && !timeout);

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = '0;
    if (is_store) begin
      st_wdata = store_data_i;
      case (funct3)
        F3_SB: begin
          st_be    = 4'b0001 << data_i[1:0];
          st_wdata = {4{store_data_i[7:0]}};
        end
        F3_SH: begin
          st_be    = data_i[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{store_data_i[15:0]}};
        end
        default: st_be = 4'b1111;
      endcase
    end
  end

  load_align u_load_align (
    .rdata  (dmem_rdata_i),
    .addr   (data_q[1:0]),
    .funct3 (instr_q[14:12]),
    .result (load_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= '0;
      instr_q      <= INST_NOP;
      data_q       <= '0;
      pc_q         <= '0;
      wbaddr_q     <= '0;
      wb_q         <= wb_bubble();
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      wb_q       <= wb_bubble();
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_i && !is_mem) begin
            wb_q <= '{valid: 1'b1, instr: instr_i, data: data_i, data_men: 32'b0,
                      pc_next: pc_next_i, wbaddr: wbaddr_i};
          end else if (valid_i && bad_align) begin
            misalign_o <= 1'b1;
          end else if (start) begin
            state        <= S_WAIT;
            wait_cnt     <= '0;
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= is_store;
            dmem_addr_o  <= {data_i[31:2], 2'b00};
            dmem_be_o    <= st_be;
            dmem_wdata_o <= st_wdata;
            instr_q      <= instr_i;
            data_q       <= data_i;
            pc_q         <= pc_next_i;
            wbaddr_q     <= wbaddr_i;
          end
        end
        S_WAIT: begin
          if (dmem_ack_i) begin
            state      <= S_IDLE;
            dmem_req_o <= 1'b0;
            wb_q <= '{valid: 1'b1, instr: instr_q, data: data_q,
                      data_men: (instr_q[6:0] == INST_TYPE_L) ? load_result : 32'b0,
                      pc_next: pc_q, wbaddr: wbaddr_q};
          end else if (timeout) begin
            state      <= S_IDLE;
            dmem_req_o <= 1'b0;
            bus_err_o  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign valid_o    = wb_q.valid;
  assign instr_o    = wb_q.instr;
  assign data_o     = wb_q.data;
  assign data_men_o = wb_q.data_men;
  assign pc_next_o  = wb_q.pc_next;
  assign wbaddr_o   = wb_q.wbaddr;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios then random traffic checked against a transaction-level model.
// Memory is modelled as a responder acking after a chosen number of wait cycles.
module tb_mem_stage;

  localparam int T = 16;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [31:0] instr_i, data_i, store_data_i, pc_next_i;
  logic [4:0]  wbaddr_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] data_men_o, data_o, pc_next_o, instr_o;
  logic [4:0]  wbaddr_o;
  logic        valid_o, stall_o, misalign_o, bus_err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .instr_i(instr_i), .data_i(data_i),
    .store_data_i(store_data_i), .pc_next_i(pc_next_i), .wbaddr_i(wbaddr_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .data_men_o(data_men_o), .data_o(data_o),
    .pc_next_o(pc_next_o), .instr_o(instr_o), .wbaddr_o(wbaddr_o), .valid_o(valid_o),
    .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from funct3.
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rdata);
    longint v;
    logic [31:0] w;
    w = rdata >> (8 * off);
    case (f3)
      3'd0: begin v = w % 256;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = w % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = w % 256;
      3'd5: v = w % 65536;
      default: v = rdata;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [3:0] model_be(input bit st, input int n, input int off);
    if (!st) return 4'hF;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input int n, input logic [31:0] sd);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w = w | (((sd >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return w;
  endfunction

  // Starts and ends just after a rising edge. delay = wait cycles before ack; delay >= T never acks.
  task automatic do_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                       input int delay, output int stalls, output logic [31:0] men_seen);
    logic [31:0] tmp, instr, pc;
    logic [4:0]  rd;
    bit          mem, ld, mis, ack, done;
    int          n, off;
    tmp   = $urandom();
    pc    = $urandom();
    rd    = 5'($urandom_range(1, 31));
    instr = {tmp[31:15], f3, rd, opc};
    mem   = (opc == OP_L) || (opc == OP_S);
    ld    = (opc == OP_L);
    n     = size_of(f3);
    off   = int'(addr % 4);
    mis   = mem && ((off % n) != 0);
    stalls = 0;
    valid_i = 1'b1; instr_i = instr; data_i = addr; store_data_i = sd;
    pc_next_i = pc; wbaddr_i = rd; dmem_ack_i = 1'b0; dmem_rdata_i = $urandom();
    @(negedge clk);
    if (stall_o) stalls++;
    chk({tag, " stall_issue"}, stall_o, mem && !mis);
    chk({tag, " req_idle"}, dmem_req_o, 1'b0);
    @(posedge clk); #1;
    if (mem && !mis) begin
      done = 0;
      for (int k = 0; k < T && !done; k++) begin
        ack = (k == delay);
        dmem_ack_i = ack;
        dmem_rdata_i = ack ? rdata : $urandom();
        @(negedge clk);
        if (stall_o) stalls++;
        chk({tag, " req"}, dmem_req_o, 1'b1);
        chk({tag, " addr"}, dmem_addr_o, addr - 32'(off));
        chk({tag, " we"}, dmem_we_o, !ld);
        chk({tag, " be"}, dmem_be_o, model_be(!ld, n, off));
        if (!ld) chk({tag, " wdata"}, dmem_wdata_o, model_wdata(n, sd));
        chk({tag, " stall_wait"}, stall_o, !ack && (k != T - 1));
        chk({tag, " bubble_wait"}, valid_o, 1'b0);
        @(posedge clk); #1;
        if (ack) done = 1;
      end
    end
    valid_i = 1'b0; dmem_ack_i = 1'b0;
    @(negedge clk);
    men_seen = data_men_o;
    chk({tag, " req_after"}, dmem_req_o, 1'b0);
    chk({tag, " misalign"}, misalign_o, mis);
    chk({tag, " bus_err"}, bus_err_o, mem && !mis && (delay >= T));
    if (mis || (mem && delay >= T)) begin
      chk({tag, " bub_valid"}, valid_o, 1'b0);
      chk({tag, " bub_instr"}, instr_o, 32'h00000013);
      chk({tag, " bub_wb"}, {wbaddr_o, data_o[26:0]}, 32'd0);
    end else begin
      chk({tag, " valid"}, valid_o, 1'b1);
      chk({tag, " instr"}, instr_o, instr);
      chk({tag, " data"}, data_o, addr);
      chk({tag, " pc"}, pc_next_o, pc);
      chk({tag, " wbaddr"}, wbaddr_o, rd);
      chk({tag, " men"}, data_men_o, ld ? model_load(f3, off, rdata) : 32'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, " pulse_end"}, {misalign_o, bus_err_o}, 2'b00);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    valid_i = 1'b0;
    dmem_ack_i = 1'($urandom_range(0, 1));
    dmem_rdata_i = $urandom();
    @(negedge clk);
    chk("idle stall", stall_o, 1'b0);
    chk("idle req", dmem_req_o, 1'b0);
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    @(negedge clk);
    chk("idle bubble", {valid_o, misalign_o, bus_err_o}, 3'b000);
    chk("idle instr", instr_o, 32'h00000013);
    @(posedge clk); #1;
  endtask

  initial begin
    int          st;
    logic [31:0] men;
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    reset = 1'b1; valid_i = 1'b0; instr_i = '0; data_i = '0; store_data_i = '0;
    pc_next_i = '0; wbaddr_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    #2;
    chk("reset valid", valid_o, 1'b0);
    chk("reset instr", instr_o, 32'h00000013);
    chk("reset data", data_men_o | data_o | pc_next_o, 32'd0);
    chk("reset pulses", {dmem_req_o, misalign_o, bus_err_o, stall_o}, 4'b0000);
    @(posedge clk); #1;
    reset = 1'b0;

    do_op("lw_100", OP_L, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 3, st, men);
    chk("lw_100 stall_cycles", 32'(st), 32'd4);
    chk("lw_100 men_const", men, 32'hDEADBEEF);
    do_op("lb_103", OP_L, 3'd0, 32'h103, 32'h0, 32'h80FFFFFF, 1, st, men);
    chk("lb_103 men_const", men, 32'hFFFFFF80);
    do_op("lbu_103", OP_L, 3'd4, 32'h103, 32'h0, 32'h80FFFFFF, 0, st, men);
    chk("lbu_103 men_const", men, 32'h00000080);
    do_op("sh_102", OP_S, 3'd1, 32'h102, 32'h0000ABCD, 32'h0, 0, st, men);
    do_op("lw_101", OP_L, 3'd2, 32'h101, 32'h0, 32'h0, 0, st, men);
    chk("lw_101 no_stall", 32'(st), 32'd0);
    do_op("sw_timeout", OP_S, 3'd2, 32'h40, 32'h12345678, 32'h0, T, st, men);
    do_op("sw_ack16", OP_S, 3'd2, 32'h44, 32'h12345678, 32'h0, T - 1, st, men);
    do_op("alu", OP_R, 3'd0, 32'hCAFEF00D, 32'h0, 32'h0, 0, st, men);
    idle_cycle();

    // Reset lands in the second wait cycle; a late ack afterwards must be ignored.
    valid_i = 1'b1; instr_i = {17'h0, 3'd2, 5'd7, OP_L}; data_i = 32'h200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_wait req_before", dmem_req_o, 1'b1);
    valid_i = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_wait req_drop", dmem_req_o, 1'b0);
    chk("rst_wait bubble", {valid_o, instr_o}, {1'b0, 32'h00000013});
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h55AA55AA;
    @(negedge clk);
    chk("late_ack req", {dmem_req_o, stall_o}, 2'b00);
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    @(negedge clk);
    chk("late_ack out", {valid_o, bus_err_o, misalign_o}, 3'b000);
    chk("late_ack men", data_men_o, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      int kind, r, dly;
      logic [2:0]  f3;
      logic [6:0]  opc;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = $urandom();
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      dly = (r < 7) ? r : ((r == 7) ? T - 1 : T);
      if (kind == 0) begin opc = OP_R; f3 = 3'($urandom_range(0, 7)); end
      else if (kind == 1) begin opc = OP_L; f3 = ld_f3[$urandom_range(0, 4)]; end
      else if (kind == 2) begin opc = OP_S; f3 = 3'($urandom_range(0, 2)); end
      else begin idle_cycle(); continue; end
      do_op($sformatf("rnd%0d", i), opc, f3, a, $urandom(), $urandom(), dly, st, men);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16, max WAIT cycles before bus error (range 2..255).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port valid_i, input, 1, EX/MEM entry holds a real instruction.
REQ-005 SHALL have port instr_i, input, 32, instruction word; opcode [6:0], funct3 [14:12].
REQ-006 SHALL have port data_i, input, 32, ALU result; effective address for loads and stores.
REQ-007 SHALL have port store_data_i, input, 32, rs2 value for stores.
REQ-008 SHALL have port pc_next_i, input, 32, PC+4 for JAL/JALR link.
REQ-009 SHALL have port wbaddr_i, input, 5, destination register.
REQ-010 SHALL have ports dmem_req_o (1), dmem_we_o (1), dmem_addr_o (32, word-aligned), dmem_wdata_o (32), dmem_be_o (4): data-memory request, all outputs.
REQ-011 SHALL have ports dmem_ack_i (1) and dmem_rdata_i (32): memory completion and read word, inputs.
REQ-012 SHALL have outputs data_men_o, data_o, pc_next_o, instr_o (32 each), wbaddr_o (5), valid_o (1): registered MEM/WB entry for the write-back stage.
REQ-013 SHALL have outputs stall_o (1, combinational, freeze upstream), misalign_o (1), bus_err_o (1): one-cycle error pulses.

Function
REQ-014 SHALL implement FSM states IDLE and WAIT.
REQ-015 IDLE: valid_i with aligned load/store -> WAIT on next edge; stall_o=1 that cycle; output register loads a bubble.
REQ-016 WAIT: dmem_req_o=1, address/we/be/wdata held stable; stall_o = ~dmem_ack_i.
REQ-017 WAIT with dmem_ack_i=1 -> IDLE; output register captures the instruction, with data_men_o = aligned load result (0 for stores).
REQ-018 Non-memory valid instruction in IDLE: passes to output register in 1 cycle, stall_o=0, no bus request.
REQ-019 Bubble: valid_o=0, instr_o=32'h00000013, wbaddr_o=0, other data outputs 0.
REQ-020 Store byte enables: SB be=4'b0001<<addr[1:0], wdata=byte replicated x4; SH be=4'b0011 (addr[1]=0) or 4'b1100, wdata=half replicated x2; SW be=4'b1111.
REQ-021 Loads: dmem_we_o=0, be=4'b1111; LB/LH sign-extend, LBU/LHU zero-extend the byte/half selected by addr[1:0]; LW passes the word.
REQ-022 Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0): no request, misalign_o=1 one cycle, bubble emitted, stall_o=0.
REQ-023 A wait counter SHALL clear on WAIT entry and increment each WAIT cycle without ack; at ACK_TIMEOUT: bus_err_o=1 one cycle, request dropped, -> IDLE, bubble emitted.
REQ-024 Ack and timeout in the same cycle: ack wins, no bus_err_o.
REQ-025 dmem_ack_i in IDLE SHALL be ignored.
REQ-026 valid_i=0: bubble, no request, no error pulses.

Reset
REQ-027 reset SHALL asynchronously force IDLE, counter 0, the bubble in all output registers, and dmem_req_o/misalign_o/bus_err_o to 0.
REQ-028 Reset during WAIT SHALL drop dmem_req_o immediately; the late ack after release SHALL be ignored.

Structure
REQ-029 Opcode constants (INST_TYPE_L, INST_TYPE_S), the load/store funct3 codes, and the NOP word SHALL live in the shared defines header.
REQ-030 Load extraction/extension SHALL be a combinational sub-module load_align (rdata, addr[1:0], funct3 -> 32-bit result).

Verification
REQ-031 LW addr 0x100, ack after 3 WAIT cycles, rdata 0xDEADBEEF -> stall_o high 4 cycles total, data_men_o=0xDEADBEEF, valid_o=1.
REQ-032 LB addr 0x103, rdata 0x80FFFFFF -> data_men_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SH addr 0x102, store_data 0x0000ABCD -> be=4'b1100, wdata=0xABCDABCD, we=1.
REQ-034 LW addr 0x101 -> misalign_o one cycle, no dmem_req_o, bubble output.
REQ-035 Aligned SW, no ack -> bus_err_o after 16 WAIT cycles, IDLE; ack on the 16th cycle -> completes, no error.
REQ-036 reset in the 2nd WAIT cycle -> dmem_req_o low immediately, bubble output; ack one cycle after release ignored.
